// File: rtl/bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory arbiter: FSM state encoding and transaction owner IDs.
package bus_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int WEN_W = 4;
endpackage

// File: rtl/bus_port_buf.sv
// Per-port completion buffer: holds the result and done flag until the pipeline advances,
// and derives the port's stall and read data.
module bus_port_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              complete,
  input  logic              pipe_stall,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              done,
  output logic              stall,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] data_buf;

  // A flushed request (en low at completion) leaves the done flag clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      data_buf <= '0;
    end else begin
      if (complete) data_buf <= bus_rdata;
      if (complete && en && pipe_stall) done <= 1'b1;
      else if (!pipe_stall)             done <= 1'b0;
    end
  end

  always_comb begin
    stall = !rst && en && !done && !complete;
    rdata = complete ? bus_rdata : data_buf;
  end
endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates ibus (fetch) and dbus (load/store) onto one address/data-phase memory bus,
// one outstanding transaction at a time.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter bit DPRIO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ibus_en,
  input  logic [AW-1:0]    ibus_addr,
  output logic [DW-1:0]    ibus_rdata,
  output logic             ibus_stall,
  input  logic             dbus_en,
  input  logic [AW-1:0]    dbus_addr,
  input  logic [WEN_W-1:0] dbus_wen,
  input  logic [DW-1:0]    dbus_wdata,
  output logic [DW-1:0]    dbus_rdata,
  output logic             dbus_stall,
  input  logic             pipe_stall,
  output logic             bus_req,
  output logic [AW-1:0]    bus_addr,
  output logic [WEN_W-1:0] bus_wen,
  output logic [DW-1:0]    bus_wdata,
  input  logic             bus_addr_ok,
  input  logic [DW-1:0]    bus_rdata,
  input  logic             bus_data_ok
);
  state_t state, state_nxt;
  owner_t owner;
  logic   i_done, d_done;
  logic   i_cand, d_cand, pick_d, issue;
  logic   complete, i_complete, d_complete;

  // State register plus the registered bus fields launched from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_wen   <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        bus_req   <= 1'b1;
        owner     <= pick_d ? OWN_D : OWN_I;
        bus_addr  <= pick_d ? dbus_addr : ibus_addr;
        bus_wen   <= pick_d ? dbus_wen : '0;
        bus_wdata <= pick_d ? dbus_wdata : '0;
      end else if (state == ADDR && bus_addr_ok) begin
        bus_req <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cand || d_cand) state_nxt = ADDR;
      ADDR:    if (bus_addr_ok)      state_nxt = DATA;
      DATA:    if (bus_data_ok)      state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // data_ok outside DATA is ignored; a port already holding a result is not eligible.
  always_comb begin
    i_cand     = ibus_en && !i_done;
    d_cand     = dbus_en && !d_done;
    pick_d     = d_cand && (DPRIO || !i_cand);
    issue      = (state == IDLE) && (i_cand || d_cand);
    complete   = (state == DATA) && bus_data_ok;
    i_complete = complete && (owner == OWN_I);
    d_complete = complete && (owner == OWN_D);
  end

  bus_port_buf #(.DATA_W(DW)) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .en         (ibus_en),
    .complete   (i_complete),
    .pipe_stall (pipe_stall),
    .bus_rdata  (bus_rdata),
    .done       (i_done),
    .stall      (ibus_stall),
    .rdata      (ibus_rdata)
  );

  bus_port_buf #(.DATA_W(DW)) u_dbuf (
    .clk        (clk),
    .rst        (rst),
    .en         (dbus_en),
    .complete   (d_complete),
    .pipe_stall (pipe_stall),
    .bus_rdata  (bus_rdata),
    .done       (d_done),
    .stall      (dbus_stall),
    .rdata      (dbus_rdata)
  );
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external SRAM-like memory bus between the instruction-fetch port (ibus) and the MEM-stage data port (dbus).
- Sequences each transfer through an address phase and a data phase, one transaction outstanding at a time.
- Generates per-port stall signals to the pipeline and buffers completed results until the pipeline advances.
- Sits between the core (IF and MEM stages) and the external memory interface.

Parameters:
- AW, 32, address width (matches AddrBus).
- DW, 32, data width (matches DataBus).
- DPRIO, 1, 1 = dbus wins simultaneous requests; 0 = ibus wins.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ibus_en  in  1  fetch request
- ibus_addr  in  AW  fetch address
- ibus_rdata  out  DW  fetch data
- ibus_stall  out  1  fetch not yet complete
- dbus_en  in  1  data request
- dbus_addr  in  AW  data address
- dbus_wen  in  4  byte write enables; 0 = read
- dbus_wdata  in  DW  store data
- dbus_rdata  out  DW  load data
- dbus_stall  out  1  data access not yet complete
- pipe_stall  in  1  global pipeline stall this cycle (OR of all stall sources)
- bus_req  out  1  address-phase request
- bus_addr  out  AW  bus address
- bus_wen  out  4  bus byte write enables
- bus_wdata  out  DW  bus write data
- bus_addr_ok  in  1  address accepted
- bus_rdata  in  DW  bus read data
- bus_data_ok  in  1  data phase complete (read data valid / write acknowledged)

Behaviour:
- Reset values: bus_req=0, bus_addr=0, bus_wen=0, bus_wdata=0, state=IDLE, i_done=d_done=0, buffers=0. ibus_stall and dbus_stall are forced 0 while rst=1.
- States:
  - IDLE: pick a winner among ports with en=1 and done=0, using DPRIO priority. Register the winner's addr/wen/wdata onto the bus, set bus_req=1, record owner, go to ADDR. With no candidate, stay in IDLE.
  - ADDR: hold bus_req and all bus fields stable. On bus_addr_ok, clear bus_req next cycle and go to DATA.
  - DATA: wait for bus_data_ok. On data_ok the transaction completes and the FSM goes to IDLE.
- bus_data_ok never arrives in the same cycle as its bus_addr_ok. Any data_ok seen in IDLE or ADDR is ignored.
- Completion cycle for the owner port (data_ok in DATA):
  - port stall=0;
  - port rdata = bus_rdata (combinational pass-through);
  - bus_rdata is captured into the port buffer;
  - if pipe_stall=1 that cycle, port done flag is set.
- Done flag: while set, port stall=0, rdata comes from the buffer, and the port is not eligible for issue. Cleared on the first cycle with pipe_stall=0.
- Stall equation: stall = en & ~done & ~(completion for this port this cycle).
- Minimum latency: request seen in IDLE at cycle 0, bus_req at cycle 1, addr_ok at cycle 1, data_ok at cycle 2, stall low in cycle 2.
- Requesters hold en/addr/wen/wdata stable while stalled.
- If the owner's en drops mid-transaction (flush), the transaction still runs to completion. The result is discarded and the done flag is not set.
- The losing port stays stalled and issues from IDLE in the cycle after the winner completes, giving a back-to-back gap of 1 cycle.
- Write completion: dbus_rdata = bus_rdata (don't care). The done semantics are identical to a read.
- Reset mid-operation: state returns to IDLE, bus_req is deasserted immediately on the next edge, and the external bus must tolerate an abandoned request.

Decomposition:
- Shared package / defines.v additions: state encoding (IDLE, ADDR, DATA), owner IDs (OWN_I, OWN_D). Width macros reuse the existing AddrBus, DataBus and ByteWEn.
- One natural sub-module: bus_port_buf, instantiated twice. It holds the done flag and data buffer, and computes stall/rdata for one port from en, complete and pipe_stall.

Test Plan:
- ibus_en=1, addr=0xBFC00000, bus_addr_ok in cycle 1, bus_data_ok in cycle 3 with rdata=0x3C1D8000 -> bus_req high cycles 1 only; ibus_stall high cycles 0-2, low cycle 3; ibus_rdata=0x3C1D8000.
- ibus and dbus both asserted in cycle 0 (dbus read 0x80000010), DPRIO=1 -> dbus transaction issued first. The ibus transaction issues only after dbus completes. ibus_stall stays high until its own data_ok.
- dbus completes with rdata=0x12345678 while pipe_stall=1 for 3 more cycles (ibus still pending) -> no reissue of the dbus request; dbus_stall=0 and dbus_rdata=0x12345678 throughout; d_done clears when pipe_stall=0.
- dbus store addr=0x80000020, wen=4'b0011, wdata=0xAABBCCDD, addr_ok delayed 4 cycles -> bus_req, bus_addr, bus_wen and bus_wdata held stable until addr_ok; completes on data_ok.
- ibus_en drops while in DATA, then data_ok arrives -> FSM returns to IDLE; i_done stays 0; no stall.
- rst asserted while in ADDR -> next cycle bus_req=0, state IDLE, all stalls 0; a stray data_ok afterward is ignored.
